// File: rtl/mmu_acc_buffer.sv
// Accumulator bank behind the 16x16 MMU: saturating add/overwrite of MMU rows
// into DEPTH entries, drained in address order over valid/ready with clear-on-read.
module mmu_acc_buffer #(
    parameter int unsigned LANES  = 16,
    parameter int unsigned IN_W   = 20,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*IN_W-1:0]   in_data,
    input  logic [ADDR_W-1:0]       in_addr,
    input  logic                    in_acc,
    input  logic                    drain_start,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*ACC_W-1:0]  out_data,
    output logic [ADDR_W-1:0]       out_addr,
    output logic                    out_last,
    output logic                    drain_done,
    output logic                    overflow
);

    typedef enum logic {S_IDLE, S_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ACC_W-1:0]  acc_q [DEPTH][LANES];
    logic [ACC_W-1:0]  acc_d [DEPTH][LANES];
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              drain_done_q, drain_done_d;
    logic              overflow_q, overflow_d;

    logic              wr_en, start_en, pop_en;
    logic [IN_W-1:0]   lane_in;
    logic [ACC_W-1:0]  lane_old;
    logic [ACC_W:0]    lane_sum;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        acc_d        = acc_q;
        overflow_d   = overflow_q;
        drain_done_d = 1'b0;
        lane_in      = '0;
        lane_old     = '0;
        lane_sum     = '0;

        // in_ready_q is low for one cycle after reset release, so gate on it too
        wr_en    = in_valid && in_ready_q;
        start_en = drain_start && in_ready_q;
        pop_en   = out_valid_q && out_ready;

        if (start_en) begin
            overflow_d = 1'b0;
            state_d    = S_DRAIN;
        end

        // Write is applied after the overflow clear so a saturating write in the
        // drain_start cycle re-arms the flag.
        if (wr_en) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                lane_in  = in_data[k*IN_W +: IN_W];
                lane_old = acc_q[in_addr][k];
                lane_sum = {{(ACC_W+1-IN_W){lane_in[IN_W-1]}}, lane_in}
                         + (in_acc ? {lane_old[ACC_W-1], lane_old} : '0);
                if (lane_sum[ACC_W] != lane_sum[ACC_W-1]) begin
                    overflow_d = 1'b1;
                    acc_d[in_addr][k] = lane_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                                        : {1'b0, {(ACC_W-1){1'b1}}};
                end else begin
                    acc_d[in_addr][k] = lane_sum[ACC_W-1:0];
                end
            end
        end

        if (pop_en) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                acc_d[ptr_q][k] = '0;
            end
            if (ptr_q == ADDR_W'(DEPTH-1)) begin
                ptr_d        = '0;
                state_d      = S_IDLE;
                drain_done_d = 1'b1;
            end else begin
                ptr_d = ptr_q + ADDR_W'(1);
            end
        end

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DRAIN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            drain_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                for (int unsigned k = 0; k < LANES; k++) begin
                    acc_q[i][k] <= '0;
                end
            end
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            drain_done_q <= drain_done_d;
            overflow_q   <= overflow_d;
            acc_q        <= acc_d;
        end
    end

    always_comb begin
        out_data = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            out_data[k*ACC_W +: ACC_W] = acc_q[ptr_q][k];
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_addr   = ptr_q;
    assign out_last   = out_valid_q && (ptr_q == ADDR_W'(DEPTH-1));
    assign drain_done = drain_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_mmu_acc_buffer.sv
// Bench for mmu_acc_buffer: directed scenarios plus random writes/drains,
// checked against an integer-arithmetic model of the accumulator bank.
module tb_mmu_acc_buffer;

    localparam int LANES  = 16;
    localparam int IN_W   = 20;
    localparam int ACC_W  = 32;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int DW     = LANES*ACC_W;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*IN_W-1:0]  in_data;
    logic [ADDR_W-1:0]      in_addr;
    logic                   in_acc;
    logic                   drain_start;
    logic                   out_valid;
    logic                   out_ready;
    logic [DW-1:0]          out_data;
    logic [ADDR_W-1:0]      out_addr;
    logic                   out_last;
    logic                   drain_done;
    logic                   overflow;

    always #5 clk = ~clk;

    mmu_acc_buffer #(
        .LANES(LANES), .IN_W(IN_W), .ACC_W(ACC_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_addr(in_addr), .in_acc(in_acc), .drain_start(drain_start),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_last(out_last), .drain_done(drain_done),
        .overflow(overflow)
    );

    int     errors = 0;
    int     checks = 0;
    longint model [DEPTH][LANES];
    bit     model_ovf;
    int     wr_lanes [LANES];

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int a = 0; a < DEPTH; a++)
            for (int k = 0; k < LANES; k++)
                model[a][k] = 0;
        model_ovf = 0;
    endtask

    task automatic exp_vec(input int a, output logic [DW-1:0] v);
        longint x;
        v = '0;
        for (int k = 0; k < LANES; k++) begin
            x = model[a][k];
            v[k*ACC_W +: ACC_W] = x[ACC_W-1:0];
        end
    endtask

    // Drives one write beat (caller advances the clock) and applies it to the model.
    task automatic drive_write(input int addr, input bit acc);
        longint s;
        int     w;
        check("in_ready_wr", in_ready, 1);
        in_valid = 1;
        in_addr  = addr[ADDR_W-1:0];
        in_acc   = acc;
        for (int k = 0; k < LANES; k++) begin
            w = wr_lanes[k];
            in_data[k*IN_W +: IN_W] = w[IN_W-1:0];
            s = longint'(w) + (acc ? model[addr][k] : 64'sd0);
            if (s > 64'sd2147483647) begin
                s = 64'sd2147483647;
                model_ovf = 1;
            end else if (s < -64'sd2147483648) begin
                s = -64'sd2147483648;
                model_ovf = 1;
            end
            model[addr][k] = s;
        end
    endtask

    task automatic rand_lanes();
        for (int k = 0; k < LANES; k++)
            wr_lanes[k] = int'($urandom_range(0, (1 << IN_W) - 1)) - (1 << (IN_W-1));
    endtask

    task automatic fill_lanes(input int v);
        for (int k = 0; k < LANES; k++) wr_lanes[k] = v;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_overflow"}, overflow, model_ovf);
    endtask

    // pct: out_ready probability in percent, -1 = repeating 1,0,0,1 pattern.
    // wr_addr >= 0 issues a write in the drain_start cycle; abort_at >= 0
    // asserts reset when that beat is presented (reset left asserted).
    task automatic run_drain(input int pct, input int wr_addr, input int abort_at);
        int ptr = 0;
        int cyc = 0;
        logic [DW-1:0] v;
        model_ovf = 0;
        if (wr_addr >= 0) drive_write(wr_addr, 0);
        drain_start = 1;
        @(negedge clk);
        drain_start = 0;
        in_valid    = 0;
        while (ptr < DEPTH && cyc < 400) begin
            check("out_valid", out_valid, 1);
            check("in_ready_drain", in_ready, 0);
            check("out_addr", out_addr, ptr);
            check("out_last", out_last, ptr == DEPTH-1);
            check("overflow_drain", overflow, model_ovf);
            exp_vec(ptr, v);
            check("out_data", out_data, v);
            if (ptr == abort_at) begin
                reset_n = 0;
                #1;
                check("abort_out_valid", out_valid, 0);
                check("abort_in_ready", in_ready, 0);
                clear_model();
                out_ready = 0;
                in_valid  = 0;
                return;
            end
            if (pct < 0) out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            else         out_ready = ($urandom_range(0, 99) < pct);
            in_valid = $urandom_range(0, 1);
            in_addr  = ADDR_W'($urandom_range(0, DEPTH-1));
            in_acc   = $urandom_range(0, 1);
            in_data[31:0] = $urandom;
            @(negedge clk);
            cyc++;
            if (out_ready) begin
                for (int k = 0; k < LANES; k++) model[ptr][k] = 0;
                ptr++;
            end
        end
        check("drain_complete", ptr, DEPTH);
        out_ready = 0;
        in_valid  = 0;
        check("drain_done", drain_done, 1);
        check_idle("post_drain");
        @(negedge clk);
        check("drain_done_pulse", drain_done, 0);
    endtask

    initial begin
        reset_n = 0; in_valid = 0; in_data = '0; in_addr = '0; in_acc = 0;
        drain_start = 0; out_ready = 0;
        clear_model();
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drain_done", drain_done, 0);
        reset_n = 1;
        @(negedge clk);
        check_idle("after_reset");

        // 1: empty drain
        run_drain(100, -1, -1);

        // 2: overwrite then accumulate
        fill_lanes(100);  drive_write(3, 0); @(negedge clk);
        fill_lanes(-30);  drive_write(3, 1); @(negedge clk);
        in_valid = 0;
        check_idle("t2");
        run_drain(100, -1, -1);

        // 3: positive saturation on lane 0, negative on lane 1
        fill_lanes(0);
        wr_lanes[0] = 524287;
        wr_lanes[1] = -524288;
        repeat (4200) begin
            drive_write(0, 1);
            @(negedge clk);
        end
        in_valid = 0;
        check_idle("t3");
        check("t3_overflow_set", overflow, 1);
        run_drain(100, -1, -1);
        check("t3_overflow_cleared", overflow, 0);

        // 4: writes attempted during drain, stalled with 1,0,0,1 ready pattern
        for (int a = 0; a < DEPTH; a += 3) begin
            rand_lanes(); drive_write(a, 0); @(negedge clk);
        end
        in_valid = 0;
        run_drain(-1, -1, -1);

        // 5: write coincident with drain_start, then clear-on-read
        fill_lanes(5);
        run_drain(100, 15, -1);
        run_drain(100, -1, -1);

        // 6: reset at beat 7
        for (int a = 0; a < DEPTH; a++) begin
            rand_lanes(); drive_write(a, 0); @(negedge clk);
        end
        in_valid = 0;
        run_drain(100, -1, 7);
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        check_idle("t6");
        run_drain(100, -1, -1);

        // random rounds
        for (int r = 0; r < 8; r++) begin
            for (int n = 0; n < 24; n++) begin
                if ($urandom_range(0, 4) == 0) begin
                    in_valid = 0;
                    @(negedge clk);
                end
                rand_lanes();
                drive_write($urandom_range(0, DEPTH-1), $urandom_range(0, 3) != 0);
                @(negedge clk);
            end
            in_valid = 0;
            check_idle("rand");
            rand_lanes();
            run_drain($urandom_range(30, 100), ($urandom_range(0, 1) != 0) ? $urandom_range(0, DEPTH-1) : -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
